// File: rtl/piso8_pkg.sv
// Shared types and defaults for the piso8 transmit path.
package piso8_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/piso8_tx_if.sv
// Load port and serial port of the piso8 transmitter, grouped as one bundle.
interface piso8_tx_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] d;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_ready;
  logic             sout_last;
  logic             busy;

  modport master (
    output d, load_valid, sout_ready,
    input  load_ready, sout, sout_valid, sout_last, busy
  );

  modport slave (
    input  d, load_valid, sout_ready,
    output load_ready, sout, sout_valid, sout_last, busy
  );

endinterface

// File: rtl/piso8_tx.sv
// Parallel-in, serial-out transmitter: loads a word on a valid/ready port and
// emits it one bit per accepted serial beat, flagging the final bit.
module piso8_tx
  import piso8_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic       clk,
  input logic       reset,
  piso8_tx_if.slave bus
);

  localparam int            CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             last_q;

  logic             beat;
  logic             load;
  logic [WIDTH-1:0] sreg_shift;

  // load_ready looks at sout_ready so a new word can land on the last beat
  assign bus.load_ready = (state == IDLE) || (last_q && bus.sout_ready);
  assign bus.sout       = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
  assign bus.sout_valid = (state == SHIFT);
  assign bus.busy       = (state == SHIFT);
  assign bus.sout_last  = last_q;

  always_comb begin
    beat       = (state == SHIFT) && bus.sout_ready;
    load       = bus.load_valid && bus.load_ready;
    sreg_shift = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sreg   <= '0;
      cnt    <= '0;
      last_q <= 1'b0;
    end else if (load) begin
      state  <= SHIFT;
      sreg   <= bus.d;
      cnt    <= '0;
      last_q <= 1'b0;
    end else if (beat) begin
      if (last_q) begin
        // counter is cleared rather than advanced so it never wraps
        state  <= IDLE;
        sreg   <= '0;
        cnt    <= '0;
        last_q <= 1'b0;
      end else begin
        sreg   <= sreg_shift;
        cnt    <= cnt + 1'b1;
        last_q <= (cnt == PENULT);
      end
    end
  end

endmodule

// File: tb/tb_piso8_tx.sv
// Directed bench for piso8_tx: one MSB-first and one LSB-first instance.
module tb_piso8_tx;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  piso8_tx_if #(.WIDTH(8)) bm ();
  piso8_tx_if #(.WIDTH(8)) bl ();

  piso8_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk   (clk),
    .reset (reset),
    .bus   (bm)
  );

  piso8_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk   (clk),
    .reset (reset),
    .bus   (bl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_serial(input string tag, input logic [7:0] s, input logic v,
                            input logic l, input logic r);
    chk({tag, ".sout"},       8'(bm.sout),       8'(s));
    chk({tag, ".sout_valid"}, 8'(bm.sout_valid), 8'(v));
    chk({tag, ".sout_last"},  8'(bm.sout_last),  8'(l));
    chk({tag, ".load_ready"}, 8'(bm.load_ready), 8'(r));
  endtask

  logic [7:0] seq;

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    bm.d = '0; bm.load_valid = 1'b0; bm.sout_ready = 1'b0;
    bl.d = '0; bl.load_valid = 1'b0; bl.sout_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();

    // reset state
    chk_serial("rst", 8'd0, 1'b0, 1'b0, 1'b1);
    chk("rst.busy", 8'(bm.busy), 8'd0);
    chk("rst.lsb_valid", 8'(bl.sout_valid), 8'd0);

    // A5 MSB first
    bm.d = 8'hA5; bm.load_valid = 1'b1; bm.sout_ready = 1'b1;
    step();
    bm.load_valid = 1'b0; bm.d = 8'h00;
    seq = 8'b1010_0101;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk_serial($sformatf("a5[%0d]", i), 8'(seq[7-i]), 1'b1, i == 7, i == 7);
      step();
    end
    #1;
    chk_serial("a5.end", 8'd0, 1'b0, 1'b0, 1'b1);
    chk("a5.busy", 8'(bm.busy), 8'd0);

    // 01 LSB first
    bl.d = 8'h01; bl.load_valid = 1'b1; bl.sout_ready = 1'b1;
    step();
    bl.load_valid = 1'b0;
    seq = 8'b1000_0000;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("lsb[%0d].sout", i), 8'(bl.sout), 8'(seq[7-i]));
      chk($sformatf("lsb[%0d].last", i), 8'(bl.sout_last), 8'(i == 7));
      step();
    end
    chk("lsb.busy", 8'(bl.busy), 8'd0);

    // back-to-back FF then 00
    bm.d = 8'hFF; bm.load_valid = 1'b1; bm.sout_ready = 1'b1;
    step();
    bm.d = 8'h00;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk_serial($sformatf("b2b[%0d]", i), 8'(i < 8), 1'b1, (i == 7) || (i == 15),
                 (i == 7) || (i == 15));
      step();
      if (i == 7) bm.load_valid = 1'b0;
    end
    chk("b2b.busy", 8'(bm.busy), 8'd0);

    // backpressure with 80; a load attempt during the stall must be ignored
    bm.d = 8'h80; bm.load_valid = 1'b1; bm.sout_ready = 1'b1;
    step();
    bm.load_valid = 1'b0;
    #1;
    chk_serial("bp.first", 8'd1, 1'b1, 1'b0, 1'b0);
    step();
    bm.sout_ready = 1'b0; bm.load_valid = 1'b1; bm.d = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_serial($sformatf("bp.stall[%0d]", i), 8'd0, 1'b1, 1'b0, 1'b0);
      step();
    end
    bm.load_valid = 1'b0; bm.sout_ready = 1'b1;
    for (int j = 1; j < 8; j++) begin
      #1;
      chk_serial($sformatf("bp[%0d]", j), 8'd0, 1'b1, j == 7, j == 7);
      step();
    end
    chk("bp.busy", 8'(bm.busy), 8'd0);

    // reset mid-word of C3, with a competing load during reset
    bm.d = 8'hC3; bm.load_valid = 1'b1;
    step();
    bm.load_valid = 1'b0;
    seq = 8'b1100_0011;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("c3[%0d].sout", i), 8'(bm.sout), 8'(seq[7-i]));
      step();
    end
    reset = 1'b1; bm.load_valid = 1'b1; bm.d = 8'hFF;
    step();
    reset = 1'b0; bm.load_valid = 1'b0;
    #1;
    chk_serial("mid_rst", 8'd0, 1'b0, 1'b0, 1'b1);
    chk("mid_rst.busy", 8'(bm.busy), 8'd0);
    step();
    chk("mid_rst.stay", 8'(bm.sout_valid), 8'd0);
    bm.d = 8'h3C; bm.load_valid = 1'b1;
    step();
    bm.load_valid = 1'b0;
    seq = 8'b0011_1100;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk_serial($sformatf("3c[%0d]", i), 8'(seq[7-i]), 1'b1, i == 7, i == 7);
      step();
    end

    // load attempt of 55 during 4th bit of F0
    bm.d = 8'hF0; bm.load_valid = 1'b1;
    step();
    bm.load_valid = 1'b0;
    seq = 8'b1111_0000;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        bm.d = 8'h55; bm.load_valid = 1'b1;
      end
      #1;
      chk_serial($sformatf("f0[%0d]", i), 8'(seq[7-i]), 1'b1, i == 7, i == 7);
      step();
      bm.load_valid = 1'b0;
    end
    chk("f0.busy", 8'(bm.busy), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
